aes_stream_packer: RTL and testbench
====================================

Name: aes_stream_packer

Overview:
- Engine-side data stage directly downstream of the AES controller FSM and its streamers.
- Gathers 32-bit plaintext words from the source stream into 128-bit blocks and hands each block to the AES round core.
- Serialises each 128-bit ciphertext result back into 32-bit words on the sink stream.
- Driven by the controller's engine ctrl (clear/start/enable); reports progress through engine flags.

Parameters:
- WORD_W, 32, stream word width in bits.
- WORDS_PER_BLOCK, 4, words per AES block. BLOCK_W = WORD_W*WORDS_PER_BLOCK = 128.
- CNT_W, 16, width of the block counters.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- clear  in  1  synchronous clear; same effect as reset
- ctrl_start_i  in  1  one-cycle start pulse from controller
- ctrl_enable_i  in  1  when low, no new input handshakes and no core start
- ctrl_nb_blocks_i  in  CNT_W  number of blocks in the job; sampled on start
- pt_data_i  in  WORD_W  plaintext word
- pt_valid_i  in  1  plaintext valid
- pt_ready_o  out  1  plaintext ready
- core_block_o  out  BLOCK_W  block presented to AES core
- core_start_o  out  1  one-cycle core start pulse
- core_done_i  in  1  one-cycle core completion pulse
- core_result_i  in  BLOCK_W  ciphertext; valid when core_done_i=1
- ct_data_o  out  WORD_W  ciphertext word
- ct_valid_o  out  1  ciphertext valid
- ct_ready_i  in  1  ciphertext ready
- flags_done_o  out  1  one-cycle pulse at job end
- flags_idle_o  out  1  high in IDLE
- blocks_done_o  out  CNT_W  blocks fully emitted in current job

Behaviour:
- Reset/clear: state IDLE; all registers zero; all outputs 0 except flags_idle_o=1.
- States: IDLE, GATHER, CORE_START, CORE_WAIT, EMIT, DONE.
- IDLE:
  - On ctrl_start_i, latch nb_blocks, zero word and block counters.
  - Go to GATHER next cycle; if nb_blocks=0, go to DONE instead.
  - ctrl_start_i in any other state is ignored.
- GATHER:
  - pt_ready_o = ctrl_enable_i. A handshake occurs when pt_valid_i & pt_ready_o.
  - Word k of the block goes to bits [BLOCK_W-1-k*WORD_W -: WORD_W], so the first word is the MSW.
  - After the handshake of word WORDS_PER_BLOCK-1, go to CORE_START.
- CORE_START:
  - If ctrl_enable_i=1: core_start_o=1 for exactly this cycle, then go to CORE_WAIT.
  - If ctrl_enable_i=0: hold in CORE_START.
- core_block_o: holds the gathered block from CORE_START until core_done_i. It is 0 only after reset/clear.
- CORE_WAIT:
  - On core_done_i, capture core_result_i into the output register and go to EMIT.
  - core_done_i is ignored in any state other than CORE_WAIT.
- EMIT:
  - ct_valid_o=1 and ct_data_o = current word, MSW first.
  - Ready is honoured regardless of ctrl_enable_i, so an asserted valid never drops before its handshake.
  - ct_data_o is stable while ct_valid_o=1 & ct_ready_i=0.
  - After the last word handshakes, blocks_done_o increments.
  - If blocks_done_o+1 == nb_blocks go to DONE, else go to GATHER.
- DONE: flags_done_o=1 for one cycle, then IDLE. blocks_done_o holds its value until the next start.
- Throughput: no overlap between gathering and emitting. Per block: 4 input cycles + 1 + core latency + 4 output cycles, minimum.
- Counters wrap modulo 2^CNT_W. nb_blocks up to 2^CNT_W-1 is supported.
- Clear mid-job aborts immediately: no done pulse; any in-flight core result is discarded.

Decomposition:
- aes_package holds:
  - aes_pack_state_t enum for the six states;
  - AES_WORD_W=32 and AES_BLOCK_W=128 constants;
  - a flags_packer_t struct {done, idle, blocks_done}.
- One sub-module, aes_block_shifter: a BLOCK_W register with a load-word-at-index port and a read-word-at-index port. It is instantiated twice, once for gather and once for emit.

Test Plan:
- Single block: nb_blocks=1; pt words 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF; stub core returns block XOR all-ones 3 cycles after start.
  -> core_block_o = 0x00112233_44556677_8899AABB_CCDDEEFF;
  -> ct words FFEEDDCC, BBAA9988, 77665544, 33221100;
  -> one flags_done_o pulse; blocks_done_o = 1.
- Three blocks with pt_valid_i toggling every other cycle and ct_ready_i low for 2 of every 3 cycles.
  -> 12 ct words in order, no duplicates or drops; blocks_done_o = 3; exactly 3 core_start_o pulses.
- nb_blocks=0 with a start pulse -> DONE pulse 2 cycles after start; pt_ready_o never high; no core_start_o.
- ctrl_enable_i=0 after word 2 of a block -> pt_ready_o=0 with no progress; after re-enable, words 3-4 are accepted and the block is correct.
- ctrl_enable_i=0 during EMIT -> output words still drain on ct_ready_i.
- clear in CORE_WAIT, followed by a core_done_i pulse -> flags_idle_o=1 the next cycle; ct_valid_o stays 0; no flags_done_o.
- Async reset_n pulse mid-EMIT -> all outputs at reset values immediately; a fresh single-block job then completes correctly.

Source files
------------

// File: rtl/aes_stream_packer_pkg.sv
// ---------------------------------------------------------------------------
// aes_package
// Shared types and constants for the AES stream packer data stage.
//   aes_pack_state_t : packer FSM states
//   AES_WORD_W       : stream word width (32)
//   AES_BLOCK_W      : AES block width (128)
//   AES_CNT_W        : block counter width (16)
//   flags_packer_t   : progress flags reported back to the controller
// ---------------------------------------------------------------------------
package aes_package;

    localparam int AES_WORD_W  = 32;
    localparam int AES_BLOCK_W = 128;
    localparam int AES_CNT_W   = 16;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_GATHER     = 3'd1,
        ST_CORE_START = 3'd2,
        ST_CORE_WAIT  = 3'd3,
        ST_EMIT       = 3'd4,
        ST_DONE       = 3'd5
    } aes_pack_state_t;

    typedef struct packed {
        logic                 done;
        logic                 idle;
        logic [AES_CNT_W-1:0] blocks_done;
    } flags_packer_t;

endpackage

// File: rtl/aes_stream_packer_shifter.sv
// ---------------------------------------------------------------------------
// aes_block_shifter
// One block-wide register addressed as a row of words. Word index 0 is the
// most significant word, so a block is filled and drained MSW first.
//   clk, reset_n, clear : clock, async active-low reset, sync clear
//   load_word_i         : write wr_word_i into word slot wr_idx_i
//   load_block_i        : write the whole block_i (takes priority)
//   rd_idx_i            : selects the word shown on rd_word_o
//   rd_word_o           : word at rd_idx_i
//   block_o             : full register contents
// ---------------------------------------------------------------------------
module aes_block_shifter
    import aes_package::*;
#(
    parameter int WORD_W = AES_WORD_W,
    parameter int WORDS  = 4,
    parameter int IDX_W  = $clog2(WORDS),
    localparam int BLOCK_W = WORD_W * WORDS
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               clear,
    input  logic               load_word_i,
    input  logic [IDX_W-1:0]   wr_idx_i,
    input  logic [WORD_W-1:0]  wr_word_i,
    input  logic               load_block_i,
    input  logic [BLOCK_W-1:0] block_i,
    input  logic [IDX_W-1:0]   rd_idx_i,
    output logic [WORD_W-1:0]  rd_word_o,
    output logic [BLOCK_W-1:0] block_o
);

    logic [BLOCK_W-1:0] block_q;

    // Whole-block load wins over a single-word write; clear behaves like reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            block_q <= '0;
        end else if (clear) begin
            block_q <= '0;
        end else if (load_block_i) begin
            block_q <= block_i;
        end else if (load_word_i) begin
            block_q[BLOCK_W-1-int'(wr_idx_i)*WORD_W -: WORD_W] <= wr_word_i;
        end
    end

    assign rd_word_o = block_q[BLOCK_W-1-int'(rd_idx_i)*WORD_W -: WORD_W];
    assign block_o   = block_q;

endmodule

// File: rtl/aes_stream_packer.sv
// ---------------------------------------------------------------------------
// aes_stream_packer
// Packs 32-bit plaintext words into 128-bit blocks for the AES round core and
// serialises each ciphertext block back into 32-bit words, MSW first.
//   clk, reset_n, clear        : clock, async active-low reset, sync clear
//   ctrl_start_i/enable_i      : job start pulse and engine enable
//   ctrl_nb_blocks_i           : blocks in the job, sampled on start
//   pt_data_i/valid_i/ready_o  : plaintext input stream
//   core_block_o/start_o       : block and start pulse to the AES core
//   core_done_i/result_i       : completion pulse and ciphertext from core
//   ct_data_o/valid_o/ready_i  : ciphertext output stream
//   flags_done_o/idle_o        : job-end pulse and idle indication
//   blocks_done_o              : blocks fully emitted in the current job
// ---------------------------------------------------------------------------
module aes_stream_packer
    import aes_package::*;
#(
    parameter int WORD_W          = AES_WORD_W,
    parameter int WORDS_PER_BLOCK = 4,
    parameter int CNT_W           = AES_CNT_W,
    localparam int BLOCK_W        = WORD_W * WORDS_PER_BLOCK
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               clear,
    input  logic               ctrl_start_i,
    input  logic               ctrl_enable_i,
    input  logic [CNT_W-1:0]   ctrl_nb_blocks_i,
    input  logic [WORD_W-1:0]  pt_data_i,
    input  logic               pt_valid_i,
    output logic               pt_ready_o,
    output logic [BLOCK_W-1:0] core_block_o,
    output logic               core_start_o,
    input  logic               core_done_i,
    input  logic [BLOCK_W-1:0] core_result_i,
    output logic [WORD_W-1:0]  ct_data_o,
    output logic               ct_valid_o,
    input  logic               ct_ready_i,
    output logic               flags_done_o,
    output logic               flags_idle_o,
    output logic [CNT_W-1:0]   blocks_done_o
);

    localparam int IDX_W = $clog2(WORDS_PER_BLOCK);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_BLOCK - 1);

    aes_pack_state_t  state_q,      state_d;
    logic [CNT_W-1:0] nbBlocks_q,   nbBlocks_d;
    logic [CNT_W-1:0] blocksDone_q, blocksDone_d;
    logic [IDX_W-1:0] wordCnt_q,    wordCnt_d;

    logic               ptHandshake;
    logic               gatherLoad;
    logic               emitLoad;
    logic [CNT_W-1:0]   blocksInc;
    logic [WORD_W-1:0]  gatherWordUnused;
    logic [BLOCK_W-1:0] emitBlockUnused;
    flags_packer_t      flags;

    assign ptHandshake = (state_q == ST_GATHER) && ctrl_enable_i && pt_valid_i;
    assign blocksInc   = blocksDone_q + CNT_W'(1);

    // Next-state logic. The word counter is shared: it addresses the gather
    // slot while collecting and the emit slot while draining, since the two
    // phases never overlap.
    always_comb begin
        state_d      = state_q;
        nbBlocks_d   = nbBlocks_q;
        blocksDone_d = blocksDone_q;
        wordCnt_d    = wordCnt_q;
        gatherLoad   = 1'b0;
        emitLoad     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ctrl_start_i) begin
                    nbBlocks_d   = ctrl_nb_blocks_i;
                    blocksDone_d = '0;
                    wordCnt_d    = '0;
                    state_d      = (ctrl_nb_blocks_i == '0) ? ST_DONE : ST_GATHER;
                end
            end
            ST_GATHER: begin
                if (ptHandshake) begin
                    gatherLoad = 1'b1;
                    if (wordCnt_q == LAST_IDX) begin
                        wordCnt_d = '0;
                        state_d   = ST_CORE_START;
                    end else begin
                        wordCnt_d = wordCnt_q + 1'b1;
                    end
                end
            end
            ST_CORE_START: begin
                if (ctrl_enable_i) begin
                    state_d = ST_CORE_WAIT;
                end
            end
            ST_CORE_WAIT: begin
                if (core_done_i) begin
                    emitLoad  = 1'b1;
                    wordCnt_d = '0;
                    state_d   = ST_EMIT;
                end
            end
            ST_EMIT: begin
                // Enable is deliberately ignored here so a raised valid
                // always completes its handshake.
                if (ct_ready_i) begin
                    if (wordCnt_q == LAST_IDX) begin
                        wordCnt_d    = '0;
                        blocksDone_d = blocksInc;
                        state_d      = (blocksInc == nbBlocks_q) ? ST_DONE : ST_GATHER;
                    end else begin
                        wordCnt_d = wordCnt_q + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and counter registers; clear aborts a job exactly like reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            nbBlocks_q   <= '0;
            blocksDone_q <= '0;
            wordCnt_q    <= '0;
        end else if (clear) begin
            state_q      <= ST_IDLE;
            nbBlocks_q   <= '0;
            blocksDone_q <= '0;
            wordCnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            nbBlocks_q   <= nbBlocks_d;
            blocksDone_q <= blocksDone_d;
            wordCnt_q    <= wordCnt_d;
        end
    end

    // Gather register doubles as the block presented to the core; it is not
    // touched between CORE_START and the core's completion.
    aes_block_shifter #(
        .WORD_W (WORD_W),
        .WORDS  (WORDS_PER_BLOCK),
        .IDX_W  (IDX_W)
    ) u_gather (
        .clk          (clk),
        .reset_n      (reset_n),
        .clear        (clear),
        .load_word_i  (gatherLoad),
        .wr_idx_i     (wordCnt_q),
        .wr_word_i    (pt_data_i),
        .load_block_i (1'b0),
        .block_i      ('0),
        .rd_idx_i     ('0),
        .rd_word_o    (gatherWordUnused),
        .block_o      (core_block_o)
    );

    // Emit register captures the ciphertext only in CORE_WAIT, so a late
    // core_done after a clear cannot leak a stale result.
    aes_block_shifter #(
        .WORD_W (WORD_W),
        .WORDS  (WORDS_PER_BLOCK),
        .IDX_W  (IDX_W)
    ) u_emit (
        .clk          (clk),
        .reset_n      (reset_n),
        .clear        (clear),
        .load_word_i  (1'b0),
        .wr_idx_i     ('0),
        .wr_word_i    ('0),
        .load_block_i (emitLoad),
        .block_i      (core_result_i),
        .rd_idx_i     (wordCnt_q),
        .rd_word_o    (ct_data_o),
        .block_o      (emitBlockUnused)
    );

    assign pt_ready_o   = (state_q == ST_GATHER) && ctrl_enable_i;
    assign core_start_o = (state_q == ST_CORE_START) && ctrl_enable_i;
    assign ct_valid_o   = (state_q == ST_EMIT);

    assign flags.done        = (state_q == ST_DONE);
    assign flags.idle        = (state_q == ST_IDLE);
    assign flags.blocks_done = AES_CNT_W'(blocksDone_q);

    assign flags_done_o  = flags.done;
    assign flags_idle_o  = flags.idle;
    assign blocks_done_o = CNT_W'(flags.blocks_done);

endmodule

// File: tb/tb_aes_stream_packer.sv
// ---------------------------------------------------------------------------
// tb_aes_stream_packer
// Self-checking bench for aes_stream_packer. The reference model treats a job
// as a list of plaintext words: every group of four forms a block (first word
// most significant) and the stub core returns the block inverted, so the
// expected ciphertext stream is simply each plaintext word inverted, in order.
// ---------------------------------------------------------------------------
module tb_aes_stream_packer;

    localparam int WORD_W  = 32;
    localparam int NWORDS  = 4;
    localparam int CNT_W   = 16;
    localparam int BLOCK_W = WORD_W * NWORDS;

    logic               clk = 1'b0;
    logic               reset_n;
    logic               clear;
    logic               ctrl_start_i;
    logic               ctrl_enable_i;
    logic [CNT_W-1:0]   ctrl_nb_blocks_i;
    logic [WORD_W-1:0]  pt_data_i;
    logic               pt_valid_i;
    logic               pt_ready_o;
    logic [BLOCK_W-1:0] core_block_o;
    logic               core_start_o;
    logic               core_done_i;
    logic [BLOCK_W-1:0] core_result_i;
    logic [WORD_W-1:0]  ct_data_o;
    logic               ct_valid_o;
    logic               ct_ready_i;
    logic               flags_done_o;
    logic               flags_idle_o;
    logic [CNT_W-1:0]   blocks_done_o;

    int compared   = 0;
    int mismatched = 0;

    logic [WORD_W-1:0]  jobWords[$];
    logic [WORD_W-1:0]  lastCt[$];
    logic [BLOCK_W-1:0] lastFirstBlock;

    aes_stream_packer dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .clear            (clear),
        .ctrl_start_i     (ctrl_start_i),
        .ctrl_enable_i    (ctrl_enable_i),
        .ctrl_nb_blocks_i (ctrl_nb_blocks_i),
        .pt_data_i        (pt_data_i),
        .pt_valid_i       (pt_valid_i),
        .pt_ready_o       (pt_ready_o),
        .core_block_o     (core_block_o),
        .core_start_o     (core_start_o),
        .core_done_i      (core_done_i),
        .core_result_i    (core_result_i),
        .ct_data_o        (ct_data_o),
        .ct_valid_o       (ct_valid_o),
        .ct_ready_i       (ct_ready_i),
        .flags_done_o     (flags_done_o),
        .flags_idle_o     (flags_idle_o),
        .blocks_done_o    (blocks_done_o)
    );

    always #5 clk = ~clk;

    // Return inputs to a quiet state between scenarios.
    task automatic idle_inputs();
        clear            = 1'b0;
        ctrl_start_i     = 1'b0;
        ctrl_enable_i    = 1'b1;
        ctrl_nb_blocks_i = '0;
        pt_data_i        = '0;
        pt_valid_i       = 1'b0;
        core_done_i      = 1'b0;
        core_result_i    = '0;
        ct_ready_i       = 1'b0;
    endtask

    // Runs one job made of jobWords. validMode/readyMode: 0 always, 1 fixed
    // pattern, 2 random. enMode: 0 on, 1 off for 6 cycles after word 2,
    // 2 off from the first core start onward. startNoise pulses a stray start.
    task automatic run_job(input int nb, input int validMode, input int readyMode,
                           input int enMode, input bit startNoise, input string tag);
        logic [WORD_W-1:0]  ptQ[$];
        logic [WORD_W-1:0]  expCt[$];
        logic [BLOCK_W-1:0] expBlocks[$];
        logic [BLOCK_W-1:0] blk;
        logic [BLOCK_W-1:0] coreRes;
        bit coreArmed, disUsed, finished, v;
        int coreDue, accepted, starts, dones, disLeft;
        coreArmed = 0; disUsed = 0; finished = 0;
        coreDue = 0; accepted = 0; starts = 0; dones = 0; disLeft = 0;
        coreRes = '0;
        lastCt.delete();
        lastFirstBlock = '0;
        blk = '0;
        for (int i = 0; i < jobWords.size(); i++) begin
            ptQ.push_back(jobWords[i]);
            expCt.push_back(~jobWords[i]);
            blk = {blk[BLOCK_W-WORD_W-1:0], jobWords[i]};
            if (i % NWORDS == NWORDS - 1) expBlocks.push_back(blk);
        end
        ctrl_nb_blocks_i = CNT_W'(nb);
        ctrl_start_i     = 1'b1;
        for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
            if (cyc > 0) begin
                ctrl_start_i     = startNoise && (cyc == 10);
                ctrl_nb_blocks_i = (startNoise && cyc == 10) ? 16'd7 : 16'd0;
            end
            if (enMode == 1 && !disUsed && accepted == 2) begin
                disUsed = 1;
                disLeft = 6;
            end
            ctrl_enable_i = !((enMode == 1 && disLeft > 0) || (enMode == 2 && starts > 0));
            case (validMode)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            pt_valid_i = (ptQ.size() > 0) && v;
            pt_data_i  = (ptQ.size() > 0) ? ptQ[0] : '0;
            case (readyMode)
                0:       ct_ready_i = 1'b1;
                1:       ct_ready_i = (cyc % 3 == 2);
                default: ct_ready_i = 1'($urandom_range(0, 1));
            endcase
            core_done_i   = coreArmed && (cyc == coreDue);
            core_result_i = core_done_i ? coreRes : '0;
            if (core_done_i) coreArmed = 0;
            #1;
            if (!ctrl_enable_i) begin
                compared++;
                if (pt_ready_o !== 1'b0 || core_start_o !== 1'b0) begin
                    mismatched++;
                    $display("[TB] FAIL %s enable_low_gating: pt_ready=%b core_start=%b, required 0/0",
                             tag, pt_ready_o, core_start_o);
                end
            end
            if (pt_valid_i && pt_ready_o === 1'b1) begin
                void'(ptQ.pop_front());
                accepted++;
            end
            if (core_start_o === 1'b1) begin
                compared++;
                if (starts >= expBlocks.size() || core_block_o !== expBlocks[starts]) begin
                    mismatched++;
                    $display("[TB] FAIL %s core_block[%0d]: got %h, required %h",
                             tag, starts, core_block_o,
                             (starts < expBlocks.size()) ? expBlocks[starts] : '0);
                end
                if (starts == 0) lastFirstBlock = core_block_o;
                starts++;
                coreArmed = 1;
                coreDue   = cyc + 3;
                coreRes   = ~core_block_o;
            end
            if (ct_valid_o === 1'b1 && ct_ready_i) lastCt.push_back(ct_data_o);
            if (flags_done_o === 1'b1) begin
                dones++;
                finished = 1;
            end
            if (disLeft > 0) disLeft--;
            @(posedge clk); #1;
        end
        idle_inputs();
        if (!finished) begin
            mismatched++;
            $display("[TB] FAIL %s timeout: no flags_done_o within 3000 cycles, required one pulse", tag);
        end
        #1;
        compared++;
        if (flags_done_o !== 1'b0 || flags_idle_o !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL %s after_done: done=%b idle=%b, required 0/1",
                     tag, flags_done_o, flags_idle_o);
        end
        compared++;
        if (blocks_done_o !== CNT_W'(nb)) begin
            mismatched++;
            $display("[TB] FAIL %s blocks_done: got %0d, required %0d", tag, blocks_done_o, nb);
        end
        compared++;
        if (starts != nb || dones != 1) begin
            mismatched++;
            $display("[TB] FAIL %s pulse_counts: starts=%0d dones=%0d, required %0d/1",
                     tag, starts, dones, nb);
        end
        compared++;
        if (lastCt.size() != expCt.size()) begin
            mismatched++;
            $display("[TB] FAIL %s ct_count: got %0d words, required %0d",
                     tag, lastCt.size(), expCt.size());
        end
        for (int i = 0; i < expCt.size() && i < lastCt.size(); i++) begin
            compared++;
            if (lastCt[i] !== expCt[i]) begin
                mismatched++;
                $display("[TB] FAIL %s ct_word[%0d]: got %h, required %h", tag, i, lastCt[i], expCt[i]);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic fill_random(input int nb);
        jobWords.delete();
        for (int i = 0; i < nb * NWORDS; i++) jobWords.push_back($urandom);
    endtask

    // Asynchronous reset at time zero; outputs must settle without a clock.
    task automatic test_reset();
        idle_inputs();
        reset_n = 1'b0;
        #12;
        compared++;
        if ({pt_ready_o, core_start_o, ct_valid_o, flags_done_o, flags_idle_o} !== 5'b00001) begin
            mismatched++;
            $display("[TB] FAIL reset_flags: got %b, required 00001",
                     {pt_ready_o, core_start_o, ct_valid_o, flags_done_o, flags_idle_o});
        end
        compared++;
        if (core_block_o !== '0 || ct_data_o !== '0 || blocks_done_o !== '0) begin
            mismatched++;
            $display("[TB] FAIL reset_data: block=%h ct=%h blocks=%0d, required all zero",
                     core_block_o, ct_data_o, blocks_done_o);
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single_block();
        logic [WORD_W-1:0] expWords[4];
        expWords = '{32'hFFEEDDCC, 32'hBBAA9988, 32'h77665544, 32'h33221100};
        jobWords = '{32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF};
        run_job(1, 0, 0, 0, 1'b0, "single");
        compared++;
        if (lastFirstBlock !== 128'h00112233_44556677_8899AABB_CCDDEEFF) begin
            mismatched++;
            $display("[TB] FAIL single core_block_literal: got %h, required 00112233445566778899aabbccddeeff",
                     lastFirstBlock);
        end
        for (int i = 0; i < 4; i++) begin
            compared++;
            if (i >= lastCt.size() || lastCt[i] !== expWords[i]) begin
                mismatched++;
                $display("[TB] FAIL single ct_literal[%0d]: got %h, required %h",
                         i, (i < lastCt.size()) ? lastCt[i] : 32'h0, expWords[i]);
            end
        end
    endtask

    task automatic test_three_blocks();
        fill_random(3);
        run_job(3, 1, 1, 0, 1'b1, "three_blocks");
    endtask

    task automatic test_zero_blocks();
        int doneCyc, dones;
        doneCyc = -1;
        dones   = 0;
        ctrl_nb_blocks_i = '0;
        ctrl_start_i     = 1'b1;
        pt_valid_i       = 1'b1;
        for (int cyc = 0; cyc < 6; cyc++) begin
            if (cyc > 0) ctrl_start_i = 1'b0;
            pt_data_i = $urandom;
            #1;
            compared++;
            if (pt_ready_o !== 1'b0 || core_start_o !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL zero_blocks quiet[%0d]: pt_ready=%b core_start=%b, required 0/0",
                         cyc, pt_ready_o, core_start_o);
            end
            if (flags_done_o === 1'b1) begin
                dones++;
                if (doneCyc < 0) doneCyc = cyc;
            end
            @(posedge clk); #1;
        end
        idle_inputs();
        compared++;
        if (dones != 1 || doneCyc < 1 || doneCyc > 2) begin
            mismatched++;
            $display("[TB] FAIL zero_blocks done_pulse: pulses=%0d first_cycle=%0d, required 1 at cycle 1..2",
                     dones, doneCyc);
        end
    endtask

    task automatic test_enable_gather();
        fill_random(1);
        run_job(1, 0, 0, 1, 1'b0, "enable_gather");
    endtask

    task automatic test_enable_emit();
        fill_random(1);
        run_job(1, 0, 2, 2, 1'b0, "enable_emit");
    endtask

    task automatic test_clear_core_wait();
        bit sawStart;
        int cnt;
        sawStart = 0;
        cnt      = 0;
        ctrl_nb_blocks_i = 16'd1;
        ctrl_start_i     = 1'b1;
        for (int cyc = 0; cyc < 40 && !sawStart; cyc++) begin
            if (cyc > 0) ctrl_start_i = 1'b0;
            pt_valid_i = (cnt < NWORDS);
            pt_data_i  = $urandom;
            #1;
            if (pt_valid_i && pt_ready_o === 1'b1) cnt++;
            if (core_start_o === 1'b1) sawStart = 1;
            @(posedge clk); #1;
        end
        pt_valid_i = 1'b0;
        if (!sawStart) begin
            mismatched++;
            $display("[TB] FAIL clear timeout: no core_start_o within 40 cycles, required one");
        end
        clear = 1'b1;
        @(posedge clk); #1;
        clear         = 1'b0;
        core_done_i   = 1'b1;
        core_result_i = {$urandom, $urandom, $urandom, $urandom};
        #1;
        compared++;
        if (flags_idle_o !== 1'b1 || core_block_o !== '0 || blocks_done_o !== '0) begin
            mismatched++;
            $display("[TB] FAIL clear idle_after_clear: idle=%b block=%h blocks=%0d, required 1/0/0",
                     flags_idle_o, core_block_o, blocks_done_o);
        end
        @(posedge clk); #1;
        core_done_i = 1'b0;
        ct_ready_i  = 1'b1;
        for (int cyc = 0; cyc < 8; cyc++) begin
            #1;
            compared++;
            if (ct_valid_o !== 1'b0 || flags_done_o !== 1'b0 || flags_idle_o !== 1'b1) begin
                mismatched++;
                $display("[TB] FAIL clear quiet[%0d]: ct_valid=%b done=%b idle=%b, required 0/0/1",
                         cyc, ct_valid_o, flags_done_o, flags_idle_o);
            end
            @(posedge clk); #1;
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid_emit();
        logic [BLOCK_W-1:0] res;
        bit sawValid;
        int due, cnt;
        res = '0; sawValid = 0; due = -1; cnt = 0;
        ct_ready_i       = 1'b0;
        ctrl_nb_blocks_i = 16'd1;
        ctrl_start_i     = 1'b1;
        for (int cyc = 0; cyc < 40 && !sawValid; cyc++) begin
            if (cyc > 0) ctrl_start_i = 1'b0;
            pt_valid_i    = (cnt < NWORDS);
            pt_data_i     = $urandom;
            core_done_i   = (cyc == due);
            core_result_i = res;
            #1;
            if (pt_valid_i && pt_ready_o === 1'b1) cnt++;
            if (core_start_o === 1'b1) begin
                due = cyc + 3;
                res = ~core_block_o;
            end
            if (ct_valid_o === 1'b1) sawValid = 1;
            else begin
                @(posedge clk); #1;
            end
        end
        pt_valid_i  = 1'b0;
        core_done_i = 1'b0;
        if (!sawValid) begin
            mismatched++;
            $display("[TB] FAIL reset_emit timeout: never reached ct_valid_o within 40 cycles");
        end
        reset_n = 1'b0;
        #1;
        compared++;
        if ({pt_ready_o, core_start_o, ct_valid_o, flags_done_o, flags_idle_o} !== 5'b00001) begin
            mismatched++;
            $display("[TB] FAIL reset_emit flags: got %b, required 00001",
                     {pt_ready_o, core_start_o, ct_valid_o, flags_done_o, flags_idle_o});
        end
        compared++;
        if (core_block_o !== '0 || ct_data_o !== '0 || blocks_done_o !== '0) begin
            mismatched++;
            $display("[TB] FAIL reset_emit data: block=%h ct=%h blocks=%0d, required all zero",
                     core_block_o, ct_data_o, blocks_done_o);
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        idle_inputs();
        @(posedge clk); #1;
        fill_random(1);
        run_job(1, 0, 0, 0, 1'b0, "after_reset");
    endtask

    task automatic test_random_jobs();
        for (int j = 0; j < 3; j++) begin
            int nb;
            nb = $urandom_range(1, 3);
            fill_random(nb);
            run_job(nb, 2, 2, 0, 1'b0, "random");
        end
    endtask

    initial begin
        test_reset();
        test_single_block();
        test_three_blocks();
        test_zero_blocks();
        test_enable_gather();
        test_enable_emit();
        test_clear_core_wait();
        test_reset_mid_emit();
        test_random_jobs();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
